// File: rtl/mul_pkg.sv
// Shared constants for the iterative 256x256 multiplier and its downstream reducer.
package mul_pkg;

    localparam int unsigned OPERAND_W      = 256;
    localparam int unsigned PRODUCT_W      = 512;
    localparam int unsigned LIMB_W_DEFAULT = 64;

    // Reducer modulus p = 2^256 - 2^168 + 1
    localparam logic [OPERAND_W-1:0] MOD_P =
        256'hffffffffffffffffffffff000000000000000000000000000000000000000001;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StMul   = 2'd1;
    localparam state_t StDrain = 2'd2;
    localparam state_t StFin   = 2'd3;

endpackage

// File: rtl/mul_limb.sv
// Registered LIMB_W x LIMB_W unsigned multiplier, one cycle of latency.
module mul_limb #(
    parameter int unsigned LIMB_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LIMB_W-1:0]     x,
    input  logic [LIMB_W-1:0]     y,
    output logic [2*LIMB_W-1:0]   prod
);

    localparam int unsigned PROD_W = 2 * LIMB_W;

    // Full-width product register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
        end else begin
            prod <= PROD_W'(x) * PROD_W'(y);
        end
    end

endmodule

// File: rtl/mul_256bit_iter.sv
// Iterative 256x256 -> 512-bit unsigned multiplier: one limb product per cycle,
// shift-accumulated into a 512-bit accumulator.
module mul_256bit_iter
    import mul_pkg::*;
#(
    parameter int unsigned LIMB_W = LIMB_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [PRODUCT_W-1:0] p
);

    localparam int unsigned NUM_LIMBS = OPERAND_W / LIMB_W;
    localparam int unsigned IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      i_q, i_d, j_q, j_d;
    logic [IDX_W-1:0]      i_dly_q, j_dly_q;
    logic                  prod_vld_q;
    logic [OPERAND_W-1:0]  a_q, a_d, b_q, b_d;
    logic [PRODUCT_W-1:0]  acc_q, acc_d;
    logic [PRODUCT_W-1:0]  p_q, p_d;
    logic                  done_q, done_d;

    logic [LIMB_W-1:0]     a_limb, b_limb;
    logic [2*LIMB_W-1:0]   prod;
    logic [PRODUCT_W-1:0]  prod_ext;
    int unsigned           shift_amt;

    // Limb selection for the current (i, j) pair
    always_comb begin
        a_limb = a_q[32'(i_q) * LIMB_W +: LIMB_W];
        b_limb = b_q[32'(j_q) * LIMB_W +: LIMB_W];
    end

    mul_limb #(
        .LIMB_W (LIMB_W)
    ) u_mul_limb (
        .clk  (clk),
        .rst  (rst),
        .x    (a_limb),
        .y    (b_limb),
        .prod (prod)
    );

    // Place the registered product at its weight using the indices delayed alongside it
    always_comb begin
        prod_ext  = PRODUCT_W'(prod);
        shift_amt = (32'(i_dly_q) + 32'(j_dly_q)) * LIMB_W;
    end

    // FSM next state, counters, operand capture, accumulation and result hold
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        done_d  = 1'b0;

        if (prod_vld_q) begin
            // Final sum fits in 512 bits, so the carry-out is dropped
            acc_d = acc_q + (prod_ext << shift_amt);
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StMul;
                end
            end
            StMul: begin
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    if (i_q == LAST_IDX) begin
                        state_d = StDrain;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StDrain: begin
                state_d = StFin;
            end
            StFin: begin
                p_d     = acc_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            i_q        <= '0;
            j_q        <= '0;
            i_dly_q    <= '0;
            j_dly_q    <= '0;
            prod_vld_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            p_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            i_dly_q    <= i_q;
            j_dly_q    <= j_q;
            prod_vld_q <= (state_q == StMul);
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            p_q        <= p_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_mul_256bit_iter.sv
// Directed bench for mul_256bit_iter: reset, latency, carry extremes, ignored
// starts, mid-operation reset and back-to-back operation.
module tb_mul_256bit_iter;

    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic         busy;
    logic         done;
    logic [511:0] p;

    int n_vec;
    int n_err;

    localparam int LATENCY = 18;

    mul_256bit_iter #(
        .LIMB_W (64)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v = {v[223:0], $urandom()};
        return v;
    endfunction

    // Single operation from IDLE; checks busy, latency and product
    task automatic run_op(input logic [255:0] av, input logic [255:0] bv, input string tag);
        int           lat;
        logic [511:0] exp;
        exp = {256'b0, av} * {256'b0, bv};
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, 512'(busy), 512'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 512'(lat), 512'(LATENCY));
        check({tag, "_p"}, p, exp);
        check({tag, "_idle"}, 512'(busy), 512'd0);
    endtask

    initial begin
        logic [255:0] a0, b0, a1, b1;
        logic [511:0] exp;
        logic [511:0] ones_sq;
        int           lat;
        int           n_done;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_done", 512'(done), 512'd0);
        check("rst_p", p, 512'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero times all-ones, then identity
        run_op(256'd0, {256{1'b1}}, "zero");
        run_op(256'd1, {4{64'h123456789abcdef0}}, "one");
        check("one_val", p, {256'b0, {4{64'h123456789abcdef0}}});

        // All-ones squared: 2^512 - 2^257 + 1
        ones_sq = {{255{1'b1}}, {256{1'b0}}, 1'b1};
        run_op({256{1'b1}}, {256{1'b1}}, "ones");
        check("ones_val", p, ones_sq);

        // Starts while busy are ignored
        a0 = {4{64'hfedcba9876543210}};
        b0 = {4{64'h0f1e2d3c4b5a6978}};
        a1 = {4{64'h1111111111111111}};
        b1 = {4{64'h2222222222222222}};
        exp = {256'b0, a0} * {256'b0, b0};
        @(negedge clk);
        a = a0; b = b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 2 || lat == 9) begin
                start = 1'b1; a = a1; b = b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("ign_lat", 512'(lat), 512'(LATENCY));
        check("ign_p", p, exp);
        @(posedge clk);
        #1;
        check("ign_no_restart", 512'(busy), 512'd0);

        // Reset at T+9 aborts; outputs clear before the next edge
        @(negedge clk);
        a = a1; b = b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 512'(busy), 512'd0);
        check("arst_done", 512'(done), 512'd0);
        check("arst_p", p, 512'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("arst_no_done", 512'(n_done), 512'd0);
        run_op(a1, b1, "post_rst");

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            a   = rand256();
            b   = rand256();
            exp = {256'b0, a} * {256'b0, b};
            @(posedge clk);
            #1;
            lat = 0;
            while (!done && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("b2b_lat", 512'(lat), 512'(LATENCY));
            check("b2b_p", p, exp);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
